// File: rtl/fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// vp_pkg
// Shared constants and types for the instruction fetch front end:
//   PC_W / INSTR_W  default program-counter and instruction widths
//   OPC_MSB/OPC_LSB opcode field position inside an instruction word
//   OPC_HALT        opcode that stops fetching
//   fetch_state_t   fetch controller FSM states
//   is_halt()       opcode decode helper used by the controller
// ----------------------------------------------------------------------------
package vp_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 23;

    localparam int OPC_MSB = 22;
    localparam int OPC_LSB = 18;

    localparam logic [4:0] OPC_HALT = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // True when the opcode field of an instruction word is the HALT opcode.
    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB] == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// fetch_ctrl_if
// Bundles the two buses of the fetch controller:
//   imem_pc / imem_instr                       combinational instruction read
//   out_valid / out_ready / out_instr / out_pc valid-ready stream to decode
// Modports:
//   master  the fetch controller side
//   slave   the memory + decode side (testbench or surrounding core)
// ----------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int PC_W    = vp_pkg::PC_W,
    parameter int INSTR_W = vp_pkg::INSTR_W
);

    logic [PC_W-1:0]    imem_pc;
    logic [INSTR_W-1:0] imem_instr;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;

    modport master (
        output imem_pc,
        input  imem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );

endinterface

// File: rtl/fetch_ctrl_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched {instr, pc} entries.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, pop     write / read strobes (ignored when full / empty)
//   flush         discards every entry; wins over push and pop
//   wdata, rdata  entry in / head entry out (rdata is 0 when empty)
//   full, empty   occupancy flags
//   count         number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter  int WIDTH = 39,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A flush cancels anything else happening in the same cycle.
    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;

    // Masking the head when empty keeps stale entries from leaking out.
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch controller: walks the pc through a combinational
// instruction memory, buffers {instr, pc} in a fetch_fifo and streams the
// buffer head to decode. A HALT opcode stops fetching; a redirect (or a
// start while active) flushes the buffer and restarts at a new pc.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, start_pc      begin fetching at start_pc (redirect when active)
//   redir_valid/redir_pc branch/jump redirect request and target
//   bus                  fetch_ctrl_if.master: imem read + decode stream
//   busy, halted         RUN / HALT state indicators
//   fetch_cnt, stall_cnt performance counters
// Build option: define FETCH_PERF_CNT_EN to implement the saturating
// performance counters; otherwise both outputs are tied to zero.
// ----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int PC_W    = vp_pkg::PC_W,
    parameter int INSTR_W = vp_pkg::INSTR_W,
    parameter int DEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    input  logic            redir_valid,
    input  logic [PC_W-1:0] redir_pc,
    fetch_ctrl_if.master    bus,
    output logic            busy,
    output logic            halted,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     stall_cnt
);

    import vp_pkg::*;

    localparam int ENTRY_W = INSTR_W + PC_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_next;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [ENTRY_W-1:0] head;

    // Once active, start and redir_valid both restart fetching; start wins
    // if both arrive together. In IDLE neither counts as a redirect.
    assign redirect    = (state != ST_IDLE) && (start || redir_valid);
    assign redirect_pc = start ? start_pc : redir_pc;

    // A redirect suppresses both the fetch and the decode hand-off so that
    // nothing from the old path is consumed in the flush cycle.
    assign push = (state == ST_RUN) && !full && !redirect;
    assign pop  = !empty && bus.out_ready && !redirect;

    // Next-state and next-pc logic.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (redirect) begin
            state_next = ST_RUN;
            pc_next    = redirect_pc;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_RUN;
                        pc_next    = start_pc;
                    end
                end
                ST_RUN: begin
                    if (push) begin
                        if (is_halt(bus.imem_instr)) begin
                            state_next = ST_HALT;
                        end else begin
                            pc_next = pc + PC_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    state_next = ST_HALT;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State and pc registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({bus.imem_instr, pc}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.imem_pc   = pc;
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = head[ENTRY_W-1:PC_W];
    assign bus.out_pc    = head[PC_W-1:0];

    assign busy   = (state == ST_RUN);
    assign halted = (state == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Saturating counters: pushes, and RUN cycles spent with a full buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state == ST_RUN) && full && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
